// File: rtl/fetch_pkg.sv
`default_nettype none
// fetch_pkg: shared widths, halt opcode and fetch FSM encoding. Rev 1.0
package fetch_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam int CNT_W   = 16;

  localparam logic [3:0] HALT_OPCODE = 4'hF;

  localparam logic [1:0] ST_ISSUE = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  typedef enum logic [1:0] {
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_READY = ST_READY,
    S_HALT  = ST_HALT
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_unit_if.sv
`default_nettype none
// inst_fetch_unit_if: decoder/control and instruction-memory bundle of the fetch unit. Rev 1.0
interface inst_fetch_unit_if #(
  parameter int PC_W    = fetch_pkg::PC_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W,
  parameter int CNT_W   = fetch_pkg::CNT_W
);

  logic               step;
  logic               jump_en;
  logic [PC_W-1:0]    jump_addr;
  logic               branch_en;
  logic               alu_zero;
  logic [PC_W-1:0]    branch_off;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic [PC_W-1:0]    pc;
  logic               halted;
  logic [CNT_W-1:0]   retired_cnt;

  // master: core / memory side; slave: the fetch unit
  modport master (
    output step, jump_en, jump_addr, branch_en, alu_zero, branch_off, imem_data,
    input  imem_addr, instr, instr_valid, pc, halted, retired_cnt
  );

  modport slave (
    input  step, jump_en, jump_addr, branch_en, alu_zero, branch_off, imem_data,
    output imem_addr, instr, instr_valid, pc, halted, retired_cnt
  );

endinterface
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// next_pc_calc: combinational next program counter (jump > taken branch > sequential). Rev 1.0
module next_pc_calc #(
  parameter int PC_W = fetch_pkg::PC_W
) (
  input  wire logic [PC_W-1:0] pc,
  input  wire logic            jump_en,
  input  wire logic [PC_W-1:0] jump_addr,
  input  wire logic            branch_en,
  input  wire logic            alu_zero,
  input  wire logic [PC_W-1:0] branch_off,
  output logic      [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] pc_inc;

  // branch_off is already PC_W wide, so modular addition is the sign extension
  always_comb begin
    pc_inc = pc + PC_W'(1);
    if (jump_en) begin
      next_pc = jump_addr;
    end else if (branch_en && alu_zero) begin
      next_pc = pc_inc + branch_off;
    end else begin
      next_pc = pc_inc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// inst_fetch_unit: owns the PC, addresses the synchronous imem and holds the fetched instruction. Rev 1.0
module inst_fetch_unit #(
  parameter int         PC_W        = fetch_pkg::PC_W,
  parameter int         INSTR_W     = fetch_pkg::INSTR_W,
  parameter logic [3:0] HALT_OPCODE = fetch_pkg::HALT_OPCODE,
  parameter int         CNT_W       = fetch_pkg::CNT_W
) (
  input wire logic clk,
  input wire logic rst,
  inst_fetch_unit_if.slave bus
);
  import fetch_pkg::*;

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    imem_addr_q, imem_addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   retired_cnt_q, retired_cnt_d;
  logic [PC_W-1:0]    next_pc;

  next_pc_calc #(.PC_W(PC_W)) u_next_pc_calc (
    .pc         (pc_q),
    .jump_en    (bus.jump_en),
    .jump_addr  (bus.jump_addr),
    .branch_en  (bus.branch_en),
    .alu_zero   (bus.alu_zero),
    .branch_off (bus.branch_off),
    .next_pc    (next_pc)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    imem_addr_d   = imem_addr_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    retired_cnt_d = retired_cnt_q;
    case (state_q)
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        instr_d = bus.imem_data;
        if (bus.imem_data[INSTR_W-1 -: 4] == HALT_OPCODE) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d       = S_READY;
          instr_valid_d = 1'b1;
        end
      end
      S_READY: begin
        if (bus.step) begin
          state_d       = S_ISSUE;
          instr_valid_d = 1'b0;
          pc_d          = next_pc;
          imem_addr_d   = next_pc;
          if (retired_cnt_q != {CNT_W{1'b1}}) begin
            retired_cnt_d = retired_cnt_q + CNT_W'(1);
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_ISSUE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_ISSUE;
      pc_q          <= '0;
      imem_addr_q   <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      retired_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imem_addr_q   <= imem_addr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign bus.imem_addr   = imem_addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc          = pc_q;
  assign bus.halted      = halted_q;
  assign bus.retired_cnt = retired_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// tb_inst_fetch_unit: directed checks of the fetch unit plus a narrow-counter instance for saturation. Rev 1.0
module tb_inst_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_sat = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] mem [256];

  always #5 clk = ~clk;

  inst_fetch_unit_if #(.PC_W(8), .INSTR_W(16), .CNT_W(16)) bus ();
  inst_fetch_unit_if #(.PC_W(8), .INSTR_W(16), .CNT_W(4))  sat_bus ();

  inst_fetch_unit #(.PC_W(8), .INSTR_W(16), .HALT_OPCODE(4'hF), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  inst_fetch_unit #(.PC_W(8), .INSTR_W(16), .HALT_OPCODE(4'hF), .CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst_sat),
    .bus (sat_bus.slave)
  );

  // synchronous memories: one cycle read latency
  always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];
  always @(posedge clk) sat_bus.imem_data <= {8'h00, sat_bus.imem_addr};

  // saturation instance steps every instruction as soon as it is valid
  assign sat_bus.step       = sat_bus.instr_valid;
  assign sat_bus.jump_en    = 1'b0;
  assign sat_bus.jump_addr  = 8'h00;
  assign sat_bus.branch_en  = 1'b0;
  assign sat_bus.alu_zero   = 1'b0;
  assign sat_bus.branch_off = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ctrl(input logic s, input logic j, input logic [7:0] ja,
                            input logic b, input logic z, input logic [7:0] off);
    bus.step       = s;
    bus.jump_en    = j;
    bus.jump_addr  = ja;
    bus.branch_en  = b;
    bus.alu_zero   = z;
    bus.branch_off = off;
  endtask

  // Called at a negedge; pulses step for one edge and waits for the next instruction.
  task automatic do_step(input string tag, input logic j, input logic [7:0] ja,
                         input logic b, input logic z, input logic [7:0] off);
    int cyc;
    drive_ctrl(1'b1, j, ja, b, z, off);
    @(negedge clk);
    drive_ctrl(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check({tag, "_drop"}, 32'(bus.instr_valid), 32'h0);
    cyc = 1;
    while (!(bus.instr_valid || bus.halted) && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd3);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
    mem[8'h00] = 16'h1234;
    mem[8'h01] = 16'h2000;
    mem[8'h50] = 16'hF000;
    drive_ctrl(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    repeat (3) @(negedge clk);
    check("rst_pc",     32'(bus.pc),          32'h0);
    check("rst_addr",   32'(bus.imem_addr),   32'h0);
    check("rst_valid",  32'(bus.instr_valid), 32'h0);
    check("rst_halted", 32'(bus.halted),      32'h0);
    check("rst_cnt",    32'(bus.retired_cnt), 32'h0);

    rst = 1'b0;
    rst_sat = 1'b0;
    @(negedge clk);
    check("first_valid_early", 32'(bus.instr_valid), 32'h0);
    @(negedge clk);
    check("first_valid", 32'(bus.instr_valid), 32'h1);
    check("first_instr", 32'(bus.instr),       32'h1234);
    check("first_pc",    32'(bus.pc),          32'h0);
    check("first_cnt",   32'(bus.retired_cnt), 32'h0);

    do_step("seq", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check("seq_pc",    32'(bus.pc),          32'h01);
    check("seq_instr", 32'(bus.instr),       32'h2000);
    check("seq_cnt",   32'(bus.retired_cnt), 32'h1);

    do_step("jmp10", 1'b1, 8'h10, 1'b0, 1'b0, 8'h00);
    check("jmp10_pc", 32'(bus.pc), 32'h10);
    do_step("br_taken", 1'b0, 8'h00, 1'b1, 1'b1, 8'hFC);
    check("br_taken_pc",    32'(bus.pc),    32'h0D);
    check("br_taken_instr", 32'(bus.instr), 32'h100D);

    do_step("jmp10b", 1'b1, 8'h10, 1'b0, 1'b0, 8'h00);
    do_step("br_nt", 1'b0, 8'h00, 1'b1, 1'b0, 8'hFC);
    check("br_nt_pc", 32'(bus.pc), 32'h11);

    do_step("jmp_prio", 1'b1, 8'h40, 1'b1, 1'b1, 8'hFC);
    check("jmp_prio_pc",    32'(bus.pc),    32'h40);
    check("jmp_prio_instr", 32'(bus.instr), 32'h1040);

    do_step("jmpff", 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00);
    check("jmpff_pc", 32'(bus.pc), 32'hFF);
    do_step("wrap", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check("wrap_pc",    32'(bus.pc),          32'h00);
    check("wrap_instr", 32'(bus.instr),       32'h1234);
    check("wrap_cnt",   32'(bus.retired_cnt), 32'h8);

    do_step("to_halt", 1'b1, 8'h50, 1'b0, 1'b0, 8'h00);
    check("halt_flag",  32'(bus.halted),      32'h1);
    check("halt_valid", 32'(bus.instr_valid), 32'h0);
    check("halt_instr", 32'(bus.instr),       32'hF000);
    check("halt_pc",    32'(bus.pc),          32'h50);
    check("halt_cnt",   32'(bus.retired_cnt), 32'h9);

    drive_ctrl(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    repeat (4) @(negedge clk);
    drive_ctrl(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("halt_step_pc",   32'(bus.pc),          32'h50);
    check("halt_step_cnt",  32'(bus.retired_cnt), 32'h9);
    check("halt_step_flag", 32'(bus.halted),      32'h1);

    rst = 1'b1;
    @(negedge clk);
    check("halt_rst_pc",     32'(bus.pc),     32'h0);
    check("halt_rst_halted", 32'(bus.halted), 32'h0);
    check("halt_rst_instr",  32'(bus.instr),  32'h0);
    check("halt_rst_cnt",    32'(bus.retired_cnt), 32'h0);

    // step during S_ISSUE, then reset while in S_WAIT
    rst = 1'b0;
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", 32'(bus.instr_valid), 32'h0);
    check("midrst_addr",  32'(bus.imem_addr),   32'h0);
    @(negedge clk);
    check("midrst_valid_early", 32'(bus.instr_valid), 32'h0);
    @(negedge clk);
    check("midrst_valid_up", 32'(bus.instr_valid), 32'h1);
    check("midrst_instr",    32'(bus.instr),       32'h1234);
    check("midrst_pc",       32'(bus.pc),          32'h0);
    check("midrst_cnt",      32'(bus.retired_cnt), 32'h0);

    repeat (80) @(negedge clk);
    check("sat_cnt", 32'(sat_bus.retired_cnt), 32'hF);
    check("sat_running", 32'(sat_bus.pc == 8'h00), 32'h0);
    repeat (12) @(negedge clk);
    check("sat_hold", 32'(sat_bus.retired_cnt), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
